pipelined_addsub_nb: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor for the riscv-jedro-1 ALU datapath. The carry chain is split into STAGES equal chunks, with one pipeline register per chunk, so long adders close timing at full throughput. The block has a valid/ready handshake on both sides, an add/subtract mode, carry-out and signed-overflow flags. It serves wide or high-frequency arithmetic where a single-cycle ripple chain is too slow.

---
 rtl/pipelined_addsub_nb_if.sv | 30 +++
 rtl/pipelined_addsub_nb.sv | 114 +++++++++++
 tb/tb_pipelined_addsub_nb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_nb_if.sv
// Handshake bundle for pipelined_addsub_nb.
// Carries the upstream request (operands, carry-in, mode, valid/ready) and
// the downstream result (sum, carry-out, signed overflow, valid/ready).
//   master : the side that issues operations and consumes results
//   slave  : the arithmetic block itself
interface pipelined_addsub_nb_if #(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         co;
    logic         ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/pipelined_addsub_nb.sv
// Pipelined N-bit adder/subtractor.
// The carry chain is cut into STAGES chunks of W = N/STAGES bits. Stage k
// adds operand chunk k plus the carry registered by stage k-1, appends the
// chunk sum to the lower sums already computed, and skews the operand chunks
// not yet consumed forward. The last stage holds the full result, the carry
// out of bit N-1 and the signed-overflow flag. A single global enable stalls
// every stage (valid bits included) while the result is held unaccepted.
// N must be a multiple of STAGES and STAGES >= 1.
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : synchronous active-low reset, clears all valid and data state
//   bus    : slave side of pipelined_addsub_nb_if
//            in_valid/in_ready, a, b, ci, sub   -> operation request
//            out_valid/out_ready, s, co, ovf    -> result
module pipelined_addsub_nb #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    pipelined_addsub_nb_if.slave   bus
);
    localparam int W = N / STAGES;

    logic en_s;
    logic last_valid_s;
    logic ovf_nxt_s;
    logic ovf_r;

    // The whole pipeline moves only when the result slot is empty or draining.
    assign en_s = !last_valid_s || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be consumed from this stage upward.
        localparam int REM = N - k * W;

        logic [REM-1:0]       op_a_s;
        logic [REM-1:0]       op_b_s;
        logic                 c_in_s;
        logic                 v_in_s;
        logic [W:0]           chunk_s;
        logic [(k+1)*W-1:0]   sum_nxt_s;
        logic [(k+1)*W-1:0]   sum_r;
        logic                 carry_r;
        logic                 valid_r;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1; the caller's carry-in is ignored then.
            assign op_a_s    = bus.a;
            assign op_b_s    = bus.sub ? ~bus.b : bus.b;
            assign c_in_s    = bus.sub ? 1'b1 : bus.ci;
            assign v_in_s    = bus.in_valid;
            assign sum_nxt_s = chunk_s[W-1:0];
        end else begin : g_src
            assign op_a_s    = g_stage[k-1].g_fwd.a_hi_r;
            assign op_b_s    = g_stage[k-1].g_fwd.b_hi_r;
            assign c_in_s    = g_stage[k-1].carry_r;
            assign v_in_s    = g_stage[k-1].valid_r;
            assign sum_nxt_s = {chunk_s[W-1:0], g_stage[k-1].sum_r};
        end

        // W-bit ripple for this chunk; bit W is the chunk carry-out.
        assign chunk_s = {1'b0, op_a_s[W-1:0]} + {1'b0, op_b_s[W-1:0]} + {{W{1'b0}}, c_in_s};

        // Stage register: accumulated low sum, chunk carry and valid bit.
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                sum_r   <= {((k+1)*W){1'b0}};
                carry_r <= 1'b0;
                valid_r <= 1'b0;
            end else if (en_s) begin
                sum_r   <= sum_nxt_s;
                carry_r <= chunk_s[W];
                valid_r <= v_in_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-W-1:0] a_hi_r;
            logic [REM-W-1:0] b_hi_r;

            // Skew the unconsumed high operand chunks alongside the partial sum.
            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    a_hi_r <= {(REM-W){1'b0}};
                    b_hi_r <= {(REM-W){1'b0}};
                end else if (en_s) begin
                    a_hi_r <= op_a_s[REM-1:W];
                    b_hi_r <= op_b_s[REM-1:W];
                end
            end
        end
    end

    // a ^ b' ^ sum at the MSB recovers the carry into bit N-1.
    assign ovf_nxt_s = g_stage[STAGES-1].op_a_s[W-1] ^ g_stage[STAGES-1].op_b_s[W-1]
                     ^ g_stage[STAGES-1].chunk_s[W-1] ^ g_stage[STAGES-1].chunk_s[W];

    // Signed-overflow flag registered together with the last stage.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ovf_r <= 1'b0;
        end else if (en_s) begin
            ovf_r <= ovf_nxt_s;
        end
    end

    assign last_valid_s  = g_stage[STAGES-1].valid_r;
    assign bus.in_ready  = en_s;
    assign bus.out_valid = last_valid_s;
    assign bus.s         = g_stage[STAGES-1].sum_r;
    assign bus.co        = g_stage[STAGES-1].carry_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_pipelined_addsub_nb.sv
// Self-checking bench for pipelined_addsub_nb (N=32, STAGES=4).
// Every accepted operation pushes its expected {co, ovf, s} and acceptance
// cycle onto a scoreboard; every accepted result pops and compares value and
// latency (STAGES cycles plus any stall cycles in between).
module tb_pipelined_addsub_nb;
    localparam int N      = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [N+1:0] exp;
        int           cyc;
        int           stalls;
    } sb_t;

    logic   clk_i = 1'b0;
    logic   rstn_i;
    sb_t    sb_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;
    int     stall_cnt    = 0;
    logic [N+1:0] drv_exp;

    pipelined_addsub_nb_if #(.N(N)) bus ();

    pipelined_addsub_nb #(.N(N), .STAGES(STAGES)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter, advanced by every rising edge.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain (N+1)-bit add; overflow from operand/result sign bits.
    function automatic logic [N+1:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic ci, input logic sub);
        logic [N-1:0] bb;
        logic [N:0]   full;
        logic [N-1:0] s;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (sub ? 1'b1 : ci)};
        s    = full[N-1:0];
        ovf  = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]);
        return {full[N], ovf, s};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic ci, input logic sub, input logic [N+1:0] exp);
        int waited = 0;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        bus.sub      = sub;
        drv_exp      = exp;
        bus.in_valid = 1'b1;
        @(negedge clk_i);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (!bus.in_ready) check_val("accept_timeout", 64'd0, 64'd1);
        @(posedge clk_i);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ci;
        logic         sub;
        a   = $urandom();
        b   = $urandom();
        ci  = 1'($urandom_range(1, 0));
        sub = 1'($urandom_range(1, 0));
        send_op(a, b, ci, sub, ref_model(a, b, ci, sub));
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                sb_q.delete();
            end else begin
                if (bus.out_valid && !bus.out_ready) stall_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("spurious_out", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_val("result", 64'({bus.co, bus.ovf, bus.s}), 64'(e.exp));
                        check_val("latency", 64'(cyc), 64'(e.cyc + STAGES + (stall_cnt - e.stalls)));
                    end
                end
                if (bus.in_valid && bus.in_ready) sb_q.push_back('{drv_exp, cyc, stall_cnt});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        check_val("watchdog", 64'd0, 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        drv_exp       = '0;
        rstn_i        = 1'b0;
        step();
        step();
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_s", 64'(bus.s), 64'd0);
        check_val("rst_co", 64'(bus.co), 64'd0);
        check_val("rst_ovf", 64'(bus.ovf), 64'd0);
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rstn_i = 1'b1;
        step();

        // Directed vectors; expected = {co, ovf, s}.
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
        send_op(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0001_0000});
        send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
        send_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        send_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});

        // Back-to-back random stream at full throughput.
        for (int i = 0; i < 16; i++) send_rand();
        for (int i = 0; i < 8; i++) step();
        check_val("drain_stream", 64'(sb_q.size()), 64'd0);

        // Output back-pressure for 3 cycles with a full pipeline.
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
            end
            begin
                n = 0;
                step();
                while (!bus.out_valid && n < 20) begin
                    step();
                    n++;
                end
                check_val("stall_reached", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_i);
                    check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    if (sb_q.size() > 0)
                        check_val("stall_hold", 64'({bus.out_valid, bus.co, bus.ovf, bus.s}),
                                  64'({1'b1, sb_q[0].exp}));
                    else
                        check_val("stall_sb_empty", 64'd0, 64'd1);
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 10; i++) step();
        check_val("drain_stall", 64'(sb_q.size()), 64'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) send_rand();
        rstn_i = 1'b0;
        step();
        check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("midrst_s", 64'(bus.s), 64'd0);
        check_val("midrst_co_ovf", 64'({bus.co, bus.ovf}), 64'd0);
        rstn_i = 1'b1;
        send_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A});
        for (int i = 0; i < 8; i++) step();
        check_val("drain_after_rst", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
